// File: rtl/fpga1_transmitter.sv
`default_nettype none
// =============================================================================
// Module : fpga1_transmitter
// Sender side of the FPGA1->FPGA2 32-bit four-phase link with abort/retry.
// Optional counters: define FPGA1_TX_STATS_EN.
// Rev    : 1.0
// =============================================================================
module fpga1_transmitter #(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              req_out,
   output logic              send_done,
   input  logic              rdy_in,
   input  logic              ack_in,
   output logic              busy,
`ifdef FPGA1_TX_STATS_EN
   output logic [31:0]       tx_word_count,
   output logic [15:0]       tx_abort_count,
`endif
   output logic              tx_timeout
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_SEND    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_ABORT   = 3'd4
   } state_t;

   state_t            state_q;
   logic              rdy_meta_q, rdy_s_q;
   logic              ack_meta_q, ack_s_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              s_ready_q;
   logic [DATA_W-1:0] data_q;
   logic              req_q;
   logic              send_done_q;
   logic              timeout_q;
   logic              w_expire;
   logic              w_word_done;
   logic              w_abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_meta_q <= 1'b0;
         rdy_s_q    <= 1'b0;
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         rdy_meta_q <= rdy_in;
         rdy_s_q    <= rdy_meta_q;
         ack_meta_q <= ack_in;
         ack_s_q    <= ack_meta_q;
      end
   end

   always_comb begin
      w_expire    = TIMEOUT_EN && (cnt_q == CNT_LAST);
      w_word_done = (state_q == ST_SEND) && ack_s_q;
      w_abort     = w_expire &&
                    (((state_q == ST_REQ)  && !rdy_s_q) ||
                     ((state_q == ST_SEND) && !ack_s_q));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         s_ready_q   <= 1'b0;
         data_q      <= '0;
         req_q       <= 1'b0;
         send_done_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!s_ready_q) begin
                  s_ready_q <= 1'b1;
               end else if (s_valid) begin
                  data_q    <= s_data;
                  s_ready_q <= 1'b0;
                  req_q     <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= ST_REQ;
               end
            end
            // A spurious ack without rdy is deliberately ignored here.
            ST_REQ: begin
               if (rdy_s_q) begin
                  send_done_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= ST_SEND;
               end else if (w_abort) begin
                  req_q     <= 1'b0;
                  timeout_q <= 1'b1;
                  state_q   <= ST_ABORT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_SEND: begin
               if (ack_s_q) begin
                  req_q       <= 1'b0;
                  send_done_q <= 1'b0;
                  state_q     <= ST_RELEASE;
               end else if (w_abort) begin
                  req_q       <= 1'b0;
                  send_done_q <= 1'b0;
                  timeout_q   <= 1'b1;
                  state_q     <= ST_ABORT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (!rdy_s_q && !ack_s_q) begin
                  s_ready_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            ST_ABORT: begin
               // Retry the retained word once the peer has fully let go.
               if (!rdy_s_q && !ack_s_q) begin
                  req_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_REQ;
               end
            end
            default: begin
               req_q       <= 1'b0;
               send_done_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FPGA1_TX_STATS_EN
   logic [31:0] word_cnt_q;
   logic [15:0] abort_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt_q  <= '0;
         abort_cnt_q <= '0;
      end else begin
         if (w_word_done) begin
            word_cnt_q <= word_cnt_q + 32'd1;
         end
         if (w_abort && (abort_cnt_q != 16'hFFFF)) begin
            abort_cnt_q <= abort_cnt_q + 16'd1;
         end
      end
   end

   assign tx_word_count  = word_cnt_q;
   assign tx_abort_count = abort_cnt_q;
`endif

   assign s_ready    = s_ready_q;
   assign data_out   = data_q;
   assign req_out    = req_q;
   assign send_done  = send_done_q;
   assign tx_timeout = timeout_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/fpga1_transmitter.md
Name: fpga1_transmitter

Overview:
Sender side of the FPGA1→FPGA2 32-bit link. It accepts words from a local valid/ready stream and presents each word on data_out. Each word is transferred with a four-phase handshake: req_out/rdy_in, then send_done/ack_in. Incoming rdy_in and ack_in come from the other FPGA's clock domain and are 2-flop synchronised. A timeout aborts a stalled word and retries it.

Parameters:
DATA_W, 32, width of data_out and s_data.
TIMEOUT_CYCLES, 1024, maximum cycles spent in REQ or SEND before abort; 0 disables the timeout.

Ports:
clk  input  1  FPGA1 clock.
rst  input  1  reset, asynchronous assert, active-high; release synchronised externally.
s_data  input  DATA_W  word to send.
s_valid  input  1  s_data valid.
s_ready  output  1  word accepted when s_valid && s_ready.
data_out  output  DATA_W  word to FPGA2; stable from REQ entry until return to IDLE.
req_out  output  1  request to FPGA2.
send_done  output  1  data valid/commit strobe to FPGA2.
rdy_in  input  1  ready from FPGA2 (async).
ack_in  input  1  acknowledge from FPGA2 (async).
busy  output  1  high in any state other than IDLE.
tx_timeout  output  1  one-cycle pulse on each abort.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; req_out, send_done, s_ready, tx_timeout, data_out all 0.
  - Synchroniser flops cleared to 0.
  - Any held word is discarded.
- Synchronisers: rdy_s and ack_s are the second flops of 2-flop chains; input-to-visible latency is 2 cycles. FSM uses only rdy_s and ack_s.
- s_ready is registered. It is 1 only while in IDLE with no retained word; first 1 is the cycle after reset release.
- IDLE:
  - On s_valid && s_ready: latch s_data into data_out, drop s_ready, go to REQ.
  - REQ entry (req_out=1) is the next cycle.
- REQ:
  - req_out=1, send_done=0, timeout counter running.
  - rdy_s=1 → go to SEND, clear counter.
  - ack_s=1 without rdy_s is ignored.
- SEND:
  - req_out=1, send_done=1.
  - ack_s=1 → go to RELEASE. send_done must have been high at least 1 cycle before ack_s is acted on.
- RELEASE:
  - req_out=0, send_done=0.
  - Leave only when rdy_s=0 && ack_s=0, then go to IDLE with s_ready=1 the next cycle.
  - No timeout here.
- Timeout: counter width $clog2(TIMEOUT_CYCLES+1). Counter cleared on REQ or SEND entry.
  - REQ or SEND held for TIMEOUT_CYCLES cycles → go to ABORT.
  - tx_timeout pulses 1 cycle; req_out and send_done drop the same cycle.
- ABORT:
  - Word retained and data_out unchanged.
  - Once rdy_s=0 && ack_s=0, go back to REQ (retry the same word).
  - No retry limit.
- Simultaneous rdy_s and ack_s in REQ: go to SEND first, never directly to RELEASE.
- Reset mid-transfer: req_out and send_done fall asynchronously. The peer sees req drop; the word is lost by design.
- Minimum per-word cost with an immediate peer: 1 accept + 2 sync + REQ + SEND + 2 sync + RELEASE exit, ≈8 cycles.

Optional Feature:
Macro: FPGA1_TX_STATS_EN.
- Defined: adds outputs tx_word_count[31:0] and tx_abort_count[15:0].
  - Both reset to 0.
  - tx_word_count increments on each SEND→RELEASE transition.
  - tx_abort_count increments on each abort and saturates at 16'hFFFF.
  - tx_word_count wraps at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, s_valid=0 → req_out=0, send_done=0, s_ready=1 from the first cycle after rst falls, busy=0.
- Single word: s_data=32'hDEADBEEF accepted; peer raises rdy_in 3 cycles after req_out, ack_in 2 cycles after send_done; peer drops both → data_out=DEADBEEF throughout, send_done rises 2 cycles after rdy_in, req_out and send_done fall 2 cycles after ack_in, s_ready returns to 1.
- Back-to-back: 4 words 1..4 with s_valid held high → exactly 4 accepts, in order. data_out never changes while req_out=1, and no new accept before RELEASE exits.
- Timeout: TIMEOUT_CYCLES=16, rdy_in held 0 → tx_timeout pulses once 16 cycles after REQ entry, req_out drops, then reasserts with the same data. Releasing rdy_in then completes the transfer (tx_abort_count=1 with FPGA1_TX_STATS_EN).
- Spurious ack: ack_in=1 in REQ with rdy_in=0 → no send_done and no state change. Then rdy_in=1 → send_done=1 → RELEASE.
- Async reset while in SEND → req_out and send_done fall within the reset cycle. After release, s_ready=1 and the held word is not resent.
